// File: rtl/dmem_byte_lanes.sv
// Big-endian byte-addressed data memory with sub-word loads, range faults.
// Optional misalignment faults: define DMEM_ALIGN_CHECK_EN.
module dmem_byte_lanes #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
   parameter int          DEPTH_BYTES = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rena,
   input  logic        wena,
   input  logic [2:0]  store_select,
   input  logic [2:0]  load_select,
   input  logic [31:0] addr,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic        rd_valid,
   output logic        addr_fault,
   output logic [31:0] fault_addr
);

   localparam int          IDX_W   = $clog2(DEPTH_BYTES);
   localparam logic [32:0] DEPTH33 = 33'(DEPTH_BYTES);

   logic [7:0]       mem_q [DEPTH_BYTES];
   logic [31:0]      data_out_q, data_out_d;
   logic             rd_valid_q, rd_valid_d;
   logic             addr_fault_q, addr_fault_d;
   logic [31:0]      fault_addr_q, fault_addr_d;

   logic [31:0]      off;
   logic [IDX_W-1:0] base_idx;
   logic [2:0]       rd_size, wr_size;
   logic             wr_legal, rd_fault, wr_fault, wr_go, fault;
   logic [7:0]       b0, b1, b2, b3;
   logic [31:0]      rd_raw;
   logic [3:0]       wr_en;
   logic [7:0]       wr_byte [4];
   logic [IDX_W-1:0] wr_idx [4];

   always_comb begin
      off      = addr - BASE_ADDR;
      base_idx = off[IDX_W-1:0];
      wr_legal = 1'b1;
      case (store_select)
         3'b001:  wr_size = 3'd1;
         3'b010:  wr_size = 3'd2;
         3'b100:  wr_size = 3'd4;
         default: begin
            wr_size  = 3'd4;
            wr_legal = 1'b0;
         end
      endcase
      case (load_select)
         3'b001, 3'b010: rd_size = 3'd1;
         3'b011, 3'b100: rd_size = 3'd2;
         default:        rd_size = 3'd4;
      endcase
      // 33-bit sum so offsets near 2^32 cannot wrap back into range
      rd_fault = (({1'b0, off} + {30'd0, rd_size}) > DEPTH33);
      wr_fault = (({1'b0, off} + {30'd0, wr_size}) > DEPTH33);
`ifdef DMEM_ALIGN_CHECK_EN
      if ((rd_size == 3'd2 && off[0]) ||
          (rd_size == 3'd4 && off[1:0] != 2'b00))
         rd_fault = 1'b1;
      if ((wr_size == 3'd2 && off[0]) ||
          (wr_size == 3'd4 && off[1:0] != 2'b00))
         wr_fault = 1'b1;
`endif
      wr_go = rst_n && wena && wr_legal && !wr_fault;
      fault = (rena && rd_fault) || (wena && wr_legal && wr_fault);

      // Lanes past the access size may alias; they are never used
      b0 = mem_q[base_idx];
      b1 = mem_q[base_idx + IDX_W'(1)];
      b2 = mem_q[base_idx + IDX_W'(2)];
      b3 = mem_q[base_idx + IDX_W'(3)];
      case (load_select)
         3'b001:  rd_raw = {{24{b0[7]}}, b0};
         3'b010:  rd_raw = {24'd0, b0};
         3'b011:  rd_raw = {{16{b0[7]}}, b0, b1};
         3'b100:  rd_raw = {16'd0, b0, b1};
         default: rd_raw = {b0, b1, b2, b3};
      endcase

      for (int k = 0; k < 4; k++) begin
         wr_en[k]  = wr_go && (k < int'(wr_size));
         wr_idx[k] = base_idx + IDX_W'(k);
         wr_byte[k] = 8'd0;
      end
      case (wr_size)
         3'd1: wr_byte[0] = data_in[7:0];
         3'd2: begin
            wr_byte[0] = data_in[15:8];
            wr_byte[1] = data_in[7:0];
         end
         default: begin
            wr_byte[0] = data_in[31:24];
            wr_byte[1] = data_in[23:16];
            wr_byte[2] = data_in[15:8];
            wr_byte[3] = data_in[7:0];
         end
      endcase

      data_out_d   = data_out_q;
      if (rena)
         data_out_d = rd_fault ? 32'd0 : rd_raw;
      rd_valid_d   = rena;
      addr_fault_d = fault;
      fault_addr_d = fault ? addr : fault_addr_q;
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++)
         if (wr_en[k])
            mem_q[wr_idx[k]] <= wr_byte[k];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_out_q   <= 32'd0;
         rd_valid_q   <= 1'b0;
         addr_fault_q <= 1'b0;
         fault_addr_q <= 32'd0;
      end else begin
         data_out_q   <= data_out_d;
         rd_valid_q   <= rd_valid_d;
         addr_fault_q <= addr_fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign data_out   = data_out_q;
   assign rd_valid   = rd_valid_q;
   assign addr_fault = addr_fault_q;
   assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_dmem_byte_lanes.sv
// Directed bench for dmem_byte_lanes: loads, stores, range faults, reset.
// Expectations follow DMEM_ALIGN_CHECK_EN when it is defined.
module tb_dmem_byte_lanes;

   localparam logic [31:0] B = 32'h1001_0000;
   localparam logic [31:0] D = 32'd1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rena, wena;
   logic [2:0]  store_select, load_select;
   logic [31:0] addr, data_in;
   logic [31:0] data_out;
   logic        rd_valid, addr_fault;
   logic [31:0] fault_addr;
   int          checks = 0;
   int          failures = 0;

   dmem_byte_lanes dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rena         (rena),
      .wena         (wena),
      .store_select (store_select),
      .load_select  (load_select),
      .addr         (addr),
      .data_in      (data_in),
      .data_out     (data_out),
      .rd_valid     (rd_valid),
      .addr_fault   (addr_fault),
      .fault_addr   (fault_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      rena = 1'b0;
      wena = 1'b0;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [31:0] a,
                     input logic [31:0] d);
      wena = 1'b1; store_select = sel; addr = a; data_in = d;
      tick();
   endtask

   task automatic rd(input logic [2:0] sel, input logic [31:0] a);
      rena = 1'b1; load_select = sel; addr = a;
      tick();
   endtask

   initial begin
      rst_n = 1'b0; rena = 1'b0; wena = 1'b0;
      store_select = 3'b000; load_select = 3'b000;
      addr = 32'd0; data_in = 32'd0;
      tick();
      tick();
      chk("rst_data", data_out, 32'd0);
      chk("rst_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_fault", {31'd0, addr_fault}, 32'd0);
      chk("rst_faddr", fault_addr, 32'd0);
      rst_n = 1'b1;

      wr(3'b100, B, 32'hA1B2C3D4);
      chk("sw_nofault", {31'd0, addr_fault}, 32'd0);
      rd(3'b000, B);
      chk("lw", data_out, 32'hA1B2C3D4);
      chk("lw_valid", {31'd0, rd_valid}, 32'd1);
      tick();
      chk("idle_valid", {31'd0, rd_valid}, 32'd0);
      chk("idle_hold", data_out, 32'hA1B2C3D4);

      rd(3'b001, B);
      chk("lb", data_out, 32'hFFFFFFA1);
      rd(3'b010, B);
      chk("lbu", data_out, 32'h000000A1);
      rd(3'b011, B + 2);
      chk("lh", data_out, 32'hFFFFC3D4);
      rd(3'b100, B + 2);
      chk("lhu", data_out, 32'h0000C3D4);
      rd(3'b111, B);
      chk("ld_illegal_lw", data_out, 32'hA1B2C3D4);

      wr(3'b001, B + 1, 32'hFFFFFF55);
      rd(3'b000, B);
      chk("sb_merge", data_out, 32'hA155C3D4);

      wr(3'b100, B + D - 4, 32'hDEADBEEF);
      wr(3'b100, B + D - 2, 32'h01020304);
      chk("sw_oor_fault", {31'd0, addr_fault}, 32'd1);
      chk("sw_oor_faddr", fault_addr, B + D - 2);
      tick();
      chk("fault_pulse", {31'd0, addr_fault}, 32'd0);
      chk("faddr_hold", fault_addr, B + D - 2);
      rd(3'b000, B + D - 4);
      chk("last_word", data_out, 32'hDEADBEEF);

      rd(3'b000, B - 4);
      chk("lw_below_data", data_out, 32'd0);
      chk("lw_below_valid", {31'd0, rd_valid}, 32'd1);
      chk("lw_below_fault", {31'd0, addr_fault}, 32'd1);
      chk("lw_below_faddr", fault_addr, B - 4);

      wr(3'b001, B + D - 1, 32'h00000080);
      rd(3'b001, B + D - 1);
      chk("lb_last", data_out, 32'hFFFFFF80);
      chk("lb_last_nofault", {31'd0, addr_fault}, 32'd0);
      rd(3'b011, B + D - 1);
      chk("lh_last_fault", {31'd0, addr_fault}, 32'd1);
      chk("lh_last_data", data_out, 32'd0);

      rena = 1'b1; load_select = 3'b000;
      wena = 1'b1; store_select = 3'b100;
      addr = B; data_in = 32'h11223344;
      tick();
      chk("rw_readfirst", data_out, 32'hA155C3D4);
      rd(3'b000, B);
      chk("rw_after", data_out, 32'h11223344);

      rena = 1'b1; load_select = 3'b000;
      wena = 1'b1; store_select = 3'b100;
      addr = B + D; data_in = 32'h0;
      tick();
      chk("rw_fault", {31'd0, addr_fault}, 32'd1);
      chk("rw_faddr", fault_addr, B + D);
      tick();
      chk("rw_fault_once", {31'd0, addr_fault}, 32'd0);

      wr(3'b011, B, 32'h0);
      chk("st_illegal_nf", {31'd0, addr_fault}, 32'd0);
      rd(3'b000, B);
      chk("st_illegal_nw", data_out, 32'h11223344);

      wr(3'b100, B + 4, 32'h55667788);
      rd(3'b000, B + 2);
`ifdef DMEM_ALIGN_CHECK_EN
      chk("lw_mis_data", data_out, 32'd0);
      chk("lw_mis_fault", {31'd0, addr_fault}, 32'd1);
`else
      chk("lw_mis_data", data_out, 32'h33445566);
      chk("lw_mis_fault", {31'd0, addr_fault}, 32'd0);
`endif

      rena = 1'b1; load_select = 3'b000; addr = B;
      rst_n = 1'b0;
      wena = 1'b1; store_select = 3'b100; data_in = 32'hCAFEF00D;
      tick();
      chk("midrst_data", data_out, 32'd0);
      chk("midrst_valid", {31'd0, rd_valid}, 32'd0);
      chk("midrst_faddr", fault_addr, 32'd0);
      rst_n = 1'b1;
      rd(3'b000, B);
      chk("mem_kept", data_out, 32'h11223344);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got=%08h exp=%08h", 32'd0, 32'd1);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_byte_lanes.md
Name: dmem_byte_lanes

Overview:
- Parametrised, byte-addressed, big-endian data memory for the MIPS pipeline MEM stage; successor to the fixed 1 KiB store-only-width DMEM.
- Adds a configurable base address and depth, and signed/unsigned sub-word loads (LB/LBU/LH/LHU/LW).
- Adds range checking, a registered read-valid, and fault reporting.

Parameters:
- BASE_ADDR, 32'h1001_0000, byte address mapped to array index 0.
- DEPTH_BYTES, 1024, array size in bytes; must be a power of two, at least 4.
- IDX_W, $clog2(DEPTH_BYTES), localparam; index width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- rena  in  1  read enable
- wena  in  1  write enable
- store_select  in  3  001 SB, 010 SH, 100 SW; other codes perform no write
- load_select  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; other codes behave as LW
- addr  in  32  byte address (absolute)
- data_in  in  32  store data; SB uses [7:0], SH uses [15:0]
- data_out  out  32  registered, extended load result
- rd_valid  out  1  data_out updated this cycle
- addr_fault  out  1  one-cycle pulse: previous-cycle access faulted
- fault_addr  out  32  address of the most recent faulting access

Behaviour:
- Index: off = addr - BASE_ADDR, 32-bit wrapping subtraction.
- Access size: SB/LB/LBU = 1 byte; SH/LH/LHU = 2 bytes; SW/LW = 4 bytes.
- Range check: an access is in range iff off + size <= DEPTH_BYTES, evaluated in 33 bits. Any byte out of range makes the whole access fault. There is no index wrap-around.
- Byte order is big-endian: the byte at off carries bits [31:24] of a word, [15:8] of a half, and [7:0] of a byte.
- Write:
  - Performed on the clk edge when rst_n=1, wena=1, store_select is legal and the access is not faulting.
  - Only the addressed bytes change.
- Read:
  - Sampled on the clk edge when rst_n=1 and rena=1; latency is 1 cycle.
  - data_out and rd_valid=1 appear the cycle after rena.
  - rd_valid=0 in any cycle without a read.
  - data_out holds its value when rena=0.
- Load extension:
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW is unmodified.
- Faulting read: data_out=0, rd_valid=1, addr_fault=1.
- Faulting write: no bytes change, addr_fault=1.
- fault_addr: loads addr on every fault and holds between faults.
- rena and wena in the same cycle:
  - Read-first: the read returns pre-write contents.
  - Both accesses share addr.
  - If they fault, the fault is reported once.
- Reset (rst_n=0 at a clk edge):
  - data_out=0, rd_valid=0, addr_fault=0, fault_addr=0.
  - Any write in that cycle is suppressed.
  - Memory contents are NOT cleared.
  - Reset asserted mid-stream discards the in-flight read result.

Optional Feature:
- Macro: DMEM_ALIGN_CHECK_EN.
- When defined, these accesses additionally fault (write suppressed, data_out=0, addr_fault=1):
  - SH/LH/LHU with off[0]=1.
  - SW/LW with off[1:0]!=0.
- When undefined, misaligned accesses are legal and byte-wise, subject only to the range check.

Test Plan:
- Reset, then SW 32'hA1B2C3D4 @ BASE_ADDR, then LW @ BASE_ADDR -> cycle after rena: data_out=32'hA1B2C3D4, rd_valid=1.
- Same word, then LB @ BASE_ADDR+0 -> 32'hFFFFFFA1; LBU @ +0 -> 32'h000000A1; LH @ +2 -> 32'hFFFFC3D4; LHU @ +2 -> 32'h0000C3D4.
- SB 8'h55 @ BASE_ADDR+1, then LW @ BASE_ADDR -> 32'hA155C3D4 (other bytes intact).
- SW @ BASE_ADDR+DEPTH_BYTES-2 -> addr_fault=1 next cycle, fault_addr=BASE_ADDR+DEPTH_BYTES-2; LW at last valid word unchanged. LW @ BASE_ADDR-4 -> data_out=0, addr_fault=1.
- rena=wena=1, SW 32'h11223344 @ BASE_ADDR over old 32'hA155C3D4 -> data_out=32'hA155C3D4; subsequent LW returns 32'h11223344.
- With DMEM_ALIGN_CHECK_EN: LW @ BASE_ADDR+2 -> addr_fault=1, data_out=0. Without it -> data_out=32'h3344xxxx (bytes +2..+5).
